// File: rtl/eth_rx_pkg.sv
// Shared types and constants for the receive admission path.
package eth_rx_pkg;

  localparam int unsigned MAC_LEN    = 6;
  localparam logic [7:0]  BCAST_BYTE = 8'hFF;

  // Admission FSM states.
  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    PASS,
    DROP
  } rx_state_t;

  // Reason a frame stops being a candidate; DR_NONE means no event this cycle.
  typedef enum logic [1:0] {
    DR_NONE,
    DR_FILTERED,
    DR_NOSPACE,
    DR_RUNT
  } drop_reason_t;

  // Byte idx of a MAC address in wire order (idx 0 is [47:40]).
  function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [2:0] idx);
    logic [7:0] b;
    case (idx)
      3'd0:    b = mac[47:40];
      3'd1:    b = mac[39:32];
      3'd2:    b = mac[31:24];
      3'd3:    b = mac[23:16];
      3'd4:    b = mac[15:8];
      3'd5:    b = mac[7:0];
      default: b = '0;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/eth_rx_delay_line.sv
// Fixed-depth shift register carrying the MAC byte stream and its strobes.
module eth_rx_delay_line #(
  parameter int unsigned DEPTH = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_dv,
  input  logic       in_good,
  input  logic       in_bad,
  output logic [7:0] out_data,
  output logic       out_dv,
  output logic       out_good,
  output logic       out_bad
);

  logic [DEPTH-1:0][7:0] data_q;
  logic [DEPTH-1:0]      dv_q;
  logic [DEPTH-1:0]      good_q;
  logic [DEPTH-1:0]      bad_q;

  // Shift every cycle; reset clears data as well as the qualifiers.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= '0;
      dv_q   <= '0;
      good_q <= '0;
      bad_q  <= '0;
    end else begin
      data_q <= {data_q[DEPTH-2:0], in_data};
      dv_q   <= {dv_q[DEPTH-2:0], in_dv};
      good_q <= {good_q[DEPTH-2:0], in_good};
      bad_q  <= {bad_q[DEPTH-2:0], in_bad};
    end
  end

  assign out_data = data_q[DEPTH-1];
  assign out_dv   = dv_q[DEPTH-1];
  assign out_good = good_q[DEPTH-1];
  assign out_bad  = bad_q[DEPTH-1];

endmodule

// File: rtl/eth_rx_admit_ctrl.sv
// Frame admission controller: delays the MAC stream by one address length and
// forwards only frames whose destination/config/header space allow it.
// Optional statistics counters are built when ETH_RX_STATS_EN is defined.
import eth_rx_pkg::*;

module eth_rx_admit_ctrl #(
  parameter int unsigned STAT_W = 16
) (
  input  logic              clientRXclock,
  input  logic              reset,
  input  logic              rxEnable,
  input  logic [47:0]       stationMAC,
  input  logic              promiscuous,
  input  logic              acceptBroadcast,
  input  logic              acceptMulticast,
  input  logic              hdrSpaceAvail,
  input  logic [7:0]        RXdata,
  input  logic              RXdataValid,
  input  logic              RXgoodFrame,
  input  logic              RXbadFrame,
  output logic [7:0]        outData,
  output logic              outDataValid,
  output logic              outGoodFrame,
  output logic              outBadFrame,
  output logic              frameActive,
  input  logic              statsClear,
  output logic [STAT_W-1:0] statAccepted,
  output logic [STAT_W-1:0] statFiltered,
  output logic [STAT_W-1:0] statNoSpace,
  output logic [STAT_W-1:0] statRunt
);

  localparam int unsigned DLY = MAC_LEN;

  rx_state_t    state;
  logic [2:0]   byte_idx;
  logic         dv_prev;
  logic         en_latched;
  logic         uc_match;
  logic         bc_match;
  logic         mc_bit;
  logic         fwd;

  logic [7:0]   d_data;
  logic         d_dv;
  logic         d_good;
  logic         d_bad;

  logic         frame_start;
  logic         end_strobe;
  logic         byte_uc;
  logic         byte_bc;
  logic         uc_final;
  logic         bc_final;
  logic         addr_hit;
  logic         accept;
  logic         runt;
  logic         decide;
  logic         leave_pass;
  drop_reason_t reason;

  eth_rx_delay_line #(.DEPTH(DLY)) u_delay (
    .clk      (clientRXclock),
    .reset    (reset),
    .in_data  (RXdata),
    .in_dv    (RXdataValid),
    .in_good  (RXgoodFrame),
    .in_bad   (RXbadFrame),
    .out_data (d_data),
    .out_dv   (d_dv),
    .out_good (d_good),
    .out_bad  (d_bad)
  );

  // Address compare and admission decision for the byte currently on the input.
  always_comb begin
    frame_start = RXdataValid & ~dv_prev;
    end_strobe  = RXgoodFrame | RXbadFrame;
    byte_uc     = (RXdata == mac_byte(stationMAC, byte_idx));
    byte_bc     = (RXdata == BCAST_BYTE);
    uc_final    = uc_match & byte_uc;
    bc_final    = bc_match & byte_bc;
    addr_hit    = promiscuous | uc_final | (acceptBroadcast & bc_final)
                | (acceptMulticast & mc_bit);
    accept      = en_latched & hdrSpaceAvail & addr_hit;
    runt        = (state == ADDR) & (~RXdataValid | end_strobe);
    decide      = (state == ADDR) & ~runt & (byte_idx == 3'(MAC_LEN - 1));
    leave_pass  = (state == PASS) & end_strobe;
    reason      = DR_NONE;
    if (runt) begin
      reason = DR_RUNT;
    end else if (decide && !accept) begin
      reason = (en_latched & addr_hit) ? DR_NOSPACE : DR_FILTERED;
    end
  end

  // Frame FSM plus the forward flag that gates the delayed stream.
  always_ff @(posedge clientRXclock) begin
    if (reset) begin
      state      <= IDLE;
      byte_idx   <= '0;
      dv_prev    <= 1'b1;
      en_latched <= 1'b0;
      uc_match   <= 1'b0;
      bc_match   <= 1'b0;
      mc_bit     <= 1'b0;
      fwd        <= 1'b0;
    end else begin
      dv_prev <= RXdataValid;
      // A new decision outranks clearing for the previous frame's end strobe.
      if (decide) begin
        fwd <= accept;
      end else if (d_good | d_bad) begin
        fwd <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (frame_start) begin
            state      <= ADDR;
            byte_idx   <= 3'd1;
            en_latched <= rxEnable;
            uc_match   <= byte_uc;
            bc_match   <= byte_bc;
            mc_bit     <= RXdata[0];
          end
        end
        ADDR: begin
          if (runt) begin
            state    <= DROP;
            byte_idx <= '0;
          end else if (decide) begin
            state    <= accept ? PASS : DROP;
            byte_idx <= '0;
          end else begin
            byte_idx <= byte_idx + 3'd1;
            uc_match <= uc_final;
            bc_match <= bc_final;
          end
        end
        PASS, DROP: begin
          if (end_strobe) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign outData      = d_data;
  assign outDataValid = d_dv & fwd;
  assign outGoodFrame = d_good & fwd;
  assign outBadFrame  = d_bad & fwd;
  assign frameActive  = (state != IDLE);

`ifdef ETH_RX_STATS_EN
  logic [STAT_W-1:0] cnt_acc;
  logic [STAT_W-1:0] cnt_filt;
  logic [STAT_W-1:0] cnt_nosp;
  logic [STAT_W-1:0] cnt_runt;

  // Saturating event counters; clear takes priority over any increment.
  always_ff @(posedge clientRXclock) begin
    if (reset || statsClear) begin
      cnt_acc  <= '0;
      cnt_filt <= '0;
      cnt_nosp <= '0;
      cnt_runt <= '0;
    end else begin
      if (leave_pass && cnt_acc != '1) cnt_acc <= cnt_acc + 1'b1;
      if (reason == DR_FILTERED && cnt_filt != '1) cnt_filt <= cnt_filt + 1'b1;
      if (reason == DR_NOSPACE && cnt_nosp != '1) cnt_nosp <= cnt_nosp + 1'b1;
      if (reason == DR_RUNT && cnt_runt != '1) cnt_runt <= cnt_runt + 1'b1;
    end
  end

  assign statAccepted = cnt_acc;
  assign statFiltered = cnt_filt;
  assign statNoSpace  = cnt_nosp;
  assign statRunt     = cnt_runt;
`else
  logic unused_stats;
  assign unused_stats = ^{statsClear, reason, leave_pass};

  assign statAccepted = '0;
  assign statFiltered = '0;
  assign statNoSpace  = '0;
  assign statRunt     = '0;
`endif

endmodule

// File: tb/tb_eth_rx_admit_ctrl.sv
// Scoreboard bench for eth_rx_admit_ctrl: frames are generated with random
// content and the expected forwarded stream is queued from address-level rules.
module tb_eth_rx_admit_ctrl;

  localparam int unsigned SW   = 5;
  localparam int          SMAX = (1 << SW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          rxEnable;
  logic [47:0]   stationMAC;
  logic          promiscuous;
  logic          acceptBroadcast;
  logic          acceptMulticast;
  logic          hdrSpaceAvail;
  logic [7:0]    RXdata;
  logic          RXdataValid;
  logic          RXgoodFrame;
  logic          RXbadFrame;
  logic [7:0]    outData;
  logic          outDataValid;
  logic          outGoodFrame;
  logic          outBadFrame;
  logic          frameActive;
  logic          statsClear;
  logic [SW-1:0] statAccepted;
  logic [SW-1:0] statFiltered;
  logic [SW-1:0] statNoSpace;
  logic [SW-1:0] statRunt;

  eth_rx_admit_ctrl #(.STAT_W(SW)) dut (
    .clientRXclock   (clk),
    .reset           (reset),
    .rxEnable        (rxEnable),
    .stationMAC      (stationMAC),
    .promiscuous     (promiscuous),
    .acceptBroadcast (acceptBroadcast),
    .acceptMulticast (acceptMulticast),
    .hdrSpaceAvail   (hdrSpaceAvail),
    .RXdata          (RXdata),
    .RXdataValid     (RXdataValid),
    .RXgoodFrame     (RXgoodFrame),
    .RXbadFrame      (RXbadFrame),
    .outData         (outData),
    .outDataValid    (outDataValid),
    .outGoodFrame    (outGoodFrame),
    .outBadFrame     (outBadFrame),
    .frameActive     (frameActive),
    .statsClear      (statsClear),
    .statAccepted    (statAccepted),
    .statFiltered    (statFiltered),
    .statNoSpace     (statNoSpace),
    .statRunt        (statRunt)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // kind: 0 = data byte, 1 = good strobe, 2 = bad strobe
  typedef struct {
    int          kind;
    logic [7:0]  data;
    int unsigned at;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   m_acc = 0, m_filt = 0, m_nosp = 0, m_runt = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic void push(input int kind, input logic [7:0] d, input int unsigned at);
    exp_t e;
    e.kind = kind;
    e.data = d;
    e.at   = at;
    exp_q.push_back(e);
  endfunction

  function automatic int sat(input int v);
    return (v < SMAX) ? v + 1 : v;
  endfunction

  task automatic check_evt(input int kind, input logic [7:0] d);
    exp_t e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL unexpected_output: kind %0d data %02h at cycle %0d, nothing expected", kind, d, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.at != cyc || (kind == 0 && e.data !== d)) begin
        n_bad++;
        $display("FAIL stream: got kind %0d data %02h cycle %0d, expected kind %0d data %02h cycle %0d",
                 kind, d, cyc, e.kind, e.data, e.at);
      end
    end
  endtask

  // Monitor: every gated output event must match the head of the scoreboard.
  always @(negedge clk) begin
    if (outDataValid === 1'b1) check_evt(0, outData);
    if (outGoodFrame === 1'b1) check_evt(1, 8'h00);
    if (outBadFrame === 1'b1)  check_evt(2, 8'h00);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_stats();
    repeat (8) tick();
    chk("frameActive_idle", frameActive, 0);
`ifdef ETH_RX_STATS_EN
    chk("statAccepted", statAccepted, m_acc);
    chk("statFiltered", statFiltered, m_filt);
    chk("statNoSpace", statNoSpace, m_nosp);
    chk("statRunt", statRunt, m_runt);
`else
    chk("statAccepted", statAccepted, 0);
    chk("statFiltered", statFiltered, 0);
    chk("statNoSpace", statNoSpace, 0);
    chk("statRunt", statRunt, 0);
`endif
  endtask

  // One frame: len bytes, an idle cycle, then the end strobe. rst_at >= 0
  // asserts reset together with that byte index.
  task automatic send_frame(input logic [47:0] dst, input int len, input bit bad,
                            input bit en, input bit space, input bit clr, input int rst_at);
    bit         addr_ok;
    bit         fwd;
    logic [7:0] b;
    addr_ok = promiscuous || (dst == stationMAC)
           || (acceptBroadcast && dst == 48'hFFFF_FFFF_FFFF)
           || (acceptMulticast && dst[40]);
    fwd = (len >= 6) && en && space && addr_ok;
    for (int i = 0; i < len; i++) begin
      b = (i < 6) ? dst[8*(5-i) +: 8] : 8'($urandom);
      RXdata        = b;
      RXdataValid   = 1'b1;
      rxEnable      = (i == 0) ? en : 1'($urandom);
      hdrSpaceAvail = (i == 5) ? space : 1'($urandom);
      reset         = (i == rst_at);
      if (fwd && (rst_at < 0 || i <= rst_at - 6)) push(0, b, cyc + 6);
      if (i == 3 && rst_at < 0) chk("frameActive_busy", frameActive, 1);
      tick();
    end
    reset       = 1'b0;
    RXdataValid = 1'b0;
    RXdata      = 8'($urandom);
    tick();
    if (bad) RXbadFrame = 1'b1;
    else     RXgoodFrame = 1'b1;
    statsClear = clr;
    if (fwd && rst_at < 0) push(bad ? 2 : 1, 8'h00, cyc + 6);
    tick();
    RXgoodFrame = 1'b0;
    RXbadFrame  = 1'b0;
    statsClear  = 1'b0;
    if (rst_at >= 0) begin
      m_acc = 0; m_filt = 0; m_nosp = 0; m_runt = 0;
    end else if (len < 6) m_runt = sat(m_runt);
    else if (fwd) m_acc = sat(m_acc);
    else if (!(en && addr_ok)) m_filt = sat(m_filt);
    else m_nosp = sat(m_nosp);
    if (clr) begin
      m_acc = 0; m_filt = 0; m_nosp = 0; m_runt = 0;
    end
  endtask

  localparam logic [47:0] STA   = 48'h02_00_00_00_00_01;
  localparam logic [47:0] OTHER = 48'h02_00_00_00_00_02;
  localparam logic [47:0] BCAST = 48'hFF_FF_FF_FF_FF_FF;
  localparam logic [47:0] MCAST = 48'h01_00_5E_00_00_01;

  initial begin
    logic [47:0] dst;
    int          len;
    reset = 1'b1; rxEnable = 1'b0; stationMAC = STA;
    promiscuous = 1'b0; acceptBroadcast = 1'b0; acceptMulticast = 1'b0;
    hdrSpaceAvail = 1'b0; RXdata = 8'h00; RXdataValid = 1'b0;
    RXgoodFrame = 1'b0; RXbadFrame = 1'b0; statsClear = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("rst_outData", outData, 0);
    chk("rst_outDataValid", outDataValid, 0);
    chk("rst_outGood", outGoodFrame, 0);
    chk("rst_outBad", outBadFrame, 0);
    chk("rst_frameActive", frameActive, 0);
    chk("rst_statRunt", statRunt, 0);

    // Directed cases
    send_frame(STA, 64, 0, 1, 1, 0, -1);   check_stats();
    send_frame(OTHER, 64, 0, 1, 1, 0, -1); check_stats();
    promiscuous = 1'b1;
    send_frame(OTHER, 64, 0, 1, 1, 0, -1); check_stats();
    promiscuous = 1'b0;
    send_frame(BCAST, 20, 0, 1, 1, 0, -1);
    acceptBroadcast = 1'b1;
    send_frame(BCAST, 20, 1, 1, 1, 0, -1);
    acceptMulticast = 1'b1;
    send_frame(MCAST, 20, 0, 1, 1, 0, -1); check_stats();
    acceptBroadcast = 1'b0; acceptMulticast = 1'b0;
    send_frame(STA, 30, 0, 1, 0, 0, -1);   check_stats();
    send_frame(STA, 30, 0, 0, 1, 0, -1);   check_stats();
    send_frame(STA, 4, 1, 1, 1, 0, -1);
    send_frame(STA, 6, 0, 1, 1, 0, -1);    check_stats();
    send_frame(STA, 40, 0, 1, 1, 0, 20);
    repeat (3) tick();
    send_frame(STA, 25, 0, 1, 1, 0, -1);   check_stats();
    send_frame(STA, 25, 0, 1, 1, 1, -1);   check_stats();

    // Randomised frames, configuration changed only between frames
    stationMAC = {16'($urandom), 32'($urandom)};
    for (int f = 0; f < 70; f++) begin
      promiscuous     = ($urandom_range(0, 3) == 0);
      acceptBroadcast = 1'($urandom);
      acceptMulticast = 1'($urandom);
      case ($urandom_range(0, 5))
        0, 1:    dst = stationMAC;
        2:       dst = stationMAC ^ (48'h1 << $urandom_range(0, 47));
        3:       dst = BCAST ^ (($urandom_range(0, 1) == 0) ? 48'h0 : (48'h1 << $urandom_range(0, 47)));
        4:       dst = {8'h01, 40'($urandom)} | 48'h01_00_00_00_00_00;
        default: dst = {16'($urandom), 32'($urandom)};
      endcase
      len = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 5)) : int'($urandom_range(6, 30));
      send_frame(dst, len, ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) != 0),
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 14) == 0), -1);
      if ($urandom_range(0, 3) == 0) check_stats();
      else repeat ($urandom_range(0, 3)) tick();
    end
    check_stats();

    // Drive the runt counter into saturation
    for (int r = 0; r < SMAX + 8; r++) send_frame(stationMAC, 3, 0, 1, 1, 0, -1);
    check_stats();

    repeat (10) tick();
    chk("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
